// File: rtl/ddr_app_pkg.sv
// Shared constants and helpers for the DDR app-interface responder.
package ddr_app_pkg;

  localparam logic [2:0]  APP_CMD_WRITE  = 3'b000;
  localparam logic [2:0]  APP_CMD_READ   = 3'b001;
  localparam int unsigned BEAT_ADDR_STEP = 8;

  typedef enum logic [2:0] {
    CMD_WRITE = APP_CMD_WRITE,
    CMD_READ  = APP_CMD_READ
  } app_cmd_e;

  function automatic logic is_valid_cmd(input logic [2:0] cmd);
    return (cmd == APP_CMD_WRITE) || (cmd == APP_CMD_READ);
  endfunction

endpackage

// File: rtl/ddr_app_responder_if.sv
// MIG-style user interface bundle: master = controller, slave = memory side.
interface ddr_app_responder_if #(
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28
);

  logic [DDR_ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]                  app_cmd;
  logic                        app_en;
  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data;
  logic                        app_wdf_end;
  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                        app_wdf_wren;
  logic                        app_rdy;
  logic                        app_wdf_rdy;
  logic [DDR_DATA_WIDTH-1:0]   app_rd_data;
  logic                        app_rd_data_valid;
  logic                        init_calib_complete;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete
  );

endinterface

// File: rtl/ddr_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through output.
module ddr_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ddr_app_responder.sv
// Memory-side model of the DDR app interface: write FIFOs, byte-masked RAM,
// fixed-latency read pipeline, calibration delay and optional back-pressure.
module ddr_app_responder
  import ddr_app_pkg::*;
#(
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned CALIB_CYCLES   = 16,
  parameter int unsigned STALL_PERIOD   = 0,
  parameter int unsigned WFIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  ddr_app_responder_if.slave app,
  output logic               err_sticky,
  output logic [15:0]        wr_beat_cnt,
  output logic [15:0]        rd_beat_cnt
);

  localparam int unsigned MASK_W    = DDR_DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = MEM_DEPTH_LOG2;
  localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned STL_W     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  logic                      calib_q, calib_d;
  logic [CAL_W-1:0]          calib_cnt_q, calib_cnt_d;
  logic [STL_W-1:0]          stall_cnt_q, stall_cnt_d;
  logic                      err_q, err_d;
  logic [15:0]               wr_cnt_q, wr_cnt_d;
  logic [15:0]               rd_cnt_q, rd_cnt_d;
  logic [RD_LATENCY-1:0]     rd_vld_q, rd_vld_d;
  logic [DDR_DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                      stall, rdy_cmd, rdy_wdf;
  logic                      cmd_acc, wr_acc, rd_acc, wdf_acc, commit;
  logic [IDX_W-1:0]          cmd_idx, waf_dout;
  logic                      waf_full, waf_empty, wdf_full, wdf_empty;
  logic [DDR_DATA_WIDTH+MASK_W-1:0] wdf_dout;
  logic [DDR_DATA_WIDTH-1:0] commit_data;
  logic [MASK_W-1:0]         commit_mask;
  logic                      unused_addr;

  logic [DDR_DATA_WIDTH-1:0] ram_mem [MEM_DEPTH];
  logic [DDR_DATA_WIDTH-1:0] rd_pipe_data [RD_LATENCY-1];

  assign cmd_idx     = app.app_addr[MEM_DEPTH_LOG2+2:3];
  assign unused_addr = ^{app.app_addr[DDR_ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], app.app_addr[2:0]};
  assign stall       = (STALL_PERIOD != 0) && (stall_cnt_q == STL_W'(STALL_PERIOD - 1));
  assign commit_data = wdf_dout[DDR_DATA_WIDTH+MASK_W-1:MASK_W];
  assign commit_mask = wdf_dout[MASK_W-1:0];

  // Reads wait for the write-address FIFO to drain, so RAM never sees a
  // same-cycle read/commit on one word and read-after-write order holds.
  always_comb begin
    rdy_cmd = calib_q & ~stall & ~waf_full & ~((app.app_cmd == APP_CMD_READ) & ~waf_empty);
    rdy_wdf = calib_q & ~stall & ~wdf_full;
    cmd_acc = app.app_en & rdy_cmd;
    wr_acc  = cmd_acc & (app.app_cmd == APP_CMD_WRITE);
    rd_acc  = cmd_acc & (app.app_cmd == APP_CMD_READ);
    wdf_acc = app.app_wdf_wren & rdy_wdf;
    commit  = ~waf_empty & ~wdf_empty;
  end

  always_comb begin
    calib_d     = calib_q;
    calib_cnt_d = calib_cnt_q;
    if (!calib_q) begin
      if (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_d = 1'b1;
      else calib_cnt_d = calib_cnt_q + CAL_W'(1);
    end
    stall_cnt_d = (STALL_PERIOD == 0 || stall) ? '0 : stall_cnt_q + STL_W'(1);
    err_d = err_q
          | (app.app_en & ~is_valid_cmd(app.app_cmd))
          | (app.app_wdf_wren & ~app.app_wdf_end)
          | (app.app_wdf_wren & ~rdy_wdf);
    wr_cnt_d  = commit ? wr_cnt_q + 16'd1 : wr_cnt_q;
    rd_cnt_d  = rd_vld_q[RD_LATENCY-1] ? rd_cnt_q + 16'd1 : rd_cnt_q;
    rd_vld_d  = {rd_vld_q[RD_LATENCY-2:0], rd_acc};
    rd_data_d = rd_vld_q[RD_LATENCY-2] ? rd_pipe_data[RD_LATENCY-2] : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calib_q     <= 1'b0;
      calib_cnt_q <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      calib_q     <= calib_d;
      calib_cnt_q <= calib_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // RAM is sampled at read acceptance; the data then rides alongside rd_vld_q.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (!commit_mask[b]) ram_mem[waf_dout][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
    rd_pipe_data[0] <= ram_mem[cmd_idx];
    for (int unsigned s = 1; s < RD_LATENCY - 1; s++) begin
      rd_pipe_data[s] <= rd_pipe_data[s-1];
    end
  end

  ddr_sync_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_waddr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_acc),
    .din   (cmd_idx),
    .pop   (commit),
    .full  (waf_full),
    .empty (waf_empty),
    .dout  (waf_dout)
  );

  ddr_sync_fifo #(
    .WIDTH (DDR_DATA_WIDTH + MASK_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wdata_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wdf_acc),
    .din   ({app.app_wdf_data, app.app_wdf_mask}),
    .pop   (commit),
    .full  (wdf_full),
    .empty (wdf_empty),
    .dout  (wdf_dout)
  );

  assign app.app_rdy             = rdy_cmd;
  assign app.app_wdf_rdy         = rdy_wdf;
  assign app.app_rd_data         = rd_data_q;
  assign app.app_rd_data_valid   = rd_vld_q[RD_LATENCY-1];
  assign app.init_calib_complete = calib_q;
  assign err_sticky              = err_q;
  assign wr_beat_cnt             = wr_cnt_q;
  assign rd_beat_cnt             = rd_cnt_q;

endmodule
